axi_lite_fifo_slave: RTL

AXI_LITE_FIFO_SLAVE -- requirements
Module: axi_lite_fifo_slave

---
 rtl/axi_lite_fifo_slave_pkg.sv | 52 +++++
 rtl/axi_lite_fifo_slave_core.sv | 97 +++++++++
 rtl/axi_lite_fifo_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_fifo_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_fifo_slave_pkg
//  Description : Shared AXI-Lite definitions for the FIFO slave: response
//                codes, resp/prot types, register offsets and the register
//                select decode used by both the read and write paths.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_fifo_slave_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] prot_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Byte offsets of the register map.
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    typedef enum logic [1:0] {
        SEL_DATA   = 2'd0,
        SEL_STATUS = 2'd1,
        SEL_CTRL   = 2'd2,
        SEL_BAD    = 2'd3
    } reg_sel_e;

    // high_nz : any address bit above bit 3 is set
    // word_sel: address bits [3:2]; bits [1:0] never take part in decode
    function automatic reg_sel_e decode_reg(input logic       high_nz,
                                            input logic [1:0] word_sel);
        reg_sel_e   sel;
        logic [3:0] ofs;
        ofs = {word_sel, 2'b00};
        sel = SEL_BAD;
        if (!high_nz) begin
            if (ofs == REG_DATA) begin
                sel = SEL_DATA;
            end else if (ofs == REG_STATUS) begin
                sel = SEL_STATUS;
            end else if (ofs == REG_CTRL) begin
                sel = SEL_CTRL;
            end
        end
        decode_reg = sel;
    endfunction

endpackage : axi_lite_fifo_slave_pkg
`default_nettype wire

// File: rtl/axi_lite_fifo_slave_core.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_core
//  Description : Single-clock FIFO storage with read/write pointers and an
//                occupancy counter. Flush has priority over push and pop.
//                push/pop requests are qualified internally against
//                full/empty, so a push while full only succeeds when a pop
//                completes on the same edge.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                push, wdata         - write request and data
//                pop, rdata          - read request, head-of-queue data
//                flush               - empty the FIFO on this edge
//                full, empty, count  - current occupancy
//                count_next          - occupancy after this edge
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] count_next
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wptr_q, wptr_d;
    ptr_t             rptr_q, rptr_d;
    cnt_t             count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (count_q == cnt_t'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign count_next = count_d;
    assign rdata = mem_q[rptr_q];

    // The pop is evaluated first, so a full FIFO still accepts a push on
    // the edge where its head leaves.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (w_do_push) begin
                wptr_d = wptr_q + ptr_t'(1);
            end
            if (w_do_pop) begin
                rptr_d = rptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(w_do_push) - cnt_t'(w_do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; a flushed write is dropped.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule : sync_fifo_core
`default_nettype wire

// File: rtl/axi_lite_fifo_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_fifo_slave
//  Description : AXI-Lite slave exposing a FIFO through three registers:
//                  0x00 DATA   write = push, read = pop
//                  0x04 STATUS bit0 empty, bit1 full, bits[16+:CW] count
//                  0x08 CTRL   bit0 flush (write-only, reads 0)
//                Other addresses return DECERR. irq is high while the
//                occupancy is at or above THRESH.
//  Ports       : clk, rst_n                   - clock, async active-low reset
//                s_aw*, s_w*, s_b*            - AXI-Lite write channels
//                s_ar*, s_r*                  - AXI-Lite read channels
//                irq                          - registered level interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_fifo_slave
    import axi_lite_fifo_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int THRESH     = DEPTH / 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // write address
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  prot_t                   s_awprot,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    // write data
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    // write response
    output resp_t                   s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    // read address
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  prot_t                   s_arprot,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    // read data
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output resp_t                   s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    // interrupt
    output logic                    irq
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [CW-1:0]         count_t;

    localparam count_t THRESH_LVL = count_t'(THRESH);

    // run_q holds all readies low until the first edge after reset release.
    logic     run_q;
    logic     bvalid_q, bvalid_d;
    resp_t    bresp_q,  bresp_d;
    logic     rvalid_q, rvalid_d;
    resp_t    rresp_q,  rresp_d;
    data_t    rdata_q,  rdata_d;
    logic     irq_q,    irq_d;

    logic     w_wr_hs;
    logic     w_rd_hs;
    reg_sel_e w_wsel;
    reg_sel_e w_rsel;
    logic     w_push;
    logic     w_pop;
    logic     w_flush;
    logic     w_full;
    logic     w_empty;
    count_t   w_count;
    count_t   w_count_next;
    data_t    w_head;
    data_t    w_status;
    logic     w_unused;

    // ------------------------------------------------------------------
    // Handshakes and address decode
    // ------------------------------------------------------------------
    assign w_wr_hs   = run_q & s_awvalid & s_wvalid & ~bvalid_q;
    assign s_awready = w_wr_hs;
    assign s_wready  = w_wr_hs;

    assign s_arready = run_q & ~rvalid_q;
    assign w_rd_hs   = s_arready & s_arvalid;

    assign w_wsel = decode_reg(|s_awaddr[ADDR_WIDTH-1:4], s_awaddr[3:2]);
    assign w_rsel = decode_reg(|s_araddr[ADDR_WIDTH-1:4], s_araddr[3:2]);

    assign w_pop   = w_rd_hs & (w_rsel == SEL_DATA) & ~w_empty;
    assign w_flush = w_wr_hs & (w_wsel == SEL_CTRL) & s_wstrb[0] & s_wdata[0];
    assign w_push  = w_wr_hs & (w_wsel == SEL_DATA) & (~w_full | w_pop);

    // Protection bits, byte strobes (other than the flush byte) and the
    // byte offset within a word carry no meaning for this slave.
    assign w_unused = ^{s_awprot, s_arprot, s_wstrb, s_awaddr[1:0], s_araddr[1:0]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    sync_fifo_core #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .wdata      (s_wdata),
        .pop        (w_pop),
        .rdata      (w_head),
        .flush      (w_flush),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count),
        .count_next (w_count_next)
    );

    always_comb begin
        w_status         = '0;
        w_status[0]      = w_empty;
        w_status[1]      = w_full;
        w_status[16 +: CW] = w_count;
    end

    // ------------------------------------------------------------------
    // Response next-state
    // ------------------------------------------------------------------
    always_comb begin
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (w_wr_hs) begin
            bvalid_d = 1'b1;
            unique case (w_wsel)
                SEL_DATA:   bresp_d = w_push ? RESP_OKAY : RESP_SLVERR;
                SEL_STATUS: bresp_d = RESP_SLVERR;
                SEL_CTRL:   bresp_d = RESP_OKAY;
                default:    bresp_d = RESP_DECERR;
            endcase
        end else if (s_bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (w_rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            unique case (w_rsel)
                SEL_DATA: begin
                    if (w_empty) begin
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rresp_d = RESP_OKAY;
                        rdata_d = w_head;
                    end
                end
                SEL_STATUS: begin
                    rresp_d = RESP_OKAY;
                    rdata_d = w_status;
                end
                SEL_CTRL: rresp_d = RESP_OKAY;
                default:  rresp_d = RESP_DECERR;
            endcase
        end else if (s_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // irq follows the post-edge occupancy so it changes on the same edge
    // as count.
    assign irq_d = (w_count_next >= THRESH_LVL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;
    assign irq      = irq_q;

endmodule : axi_lite_fifo_slave
`default_nettype wire
